i2s_transmitter: RTL

- I2S serial transmitter, the counterpart of the team's I2S receiver, clocked directly by the bit clock.
- Accepts parallel left/right sample pairs over a valid/ready handshake and buffers one pair.
- Generates wordSelect and serial data, MSB first, with the standard I2S one-bit delay after each wordSelect edge.
- Its outputs drive the receiver directly or go off-chip to a DAC.

---
 rtl/i2s_transmitter.sv | 105 ++++++++++
 1 files changed

// File: rtl/i2s_transmitter.sv
// I2S serial transmitter clocked by the bit clock: buffers one left/right pair behind a
// valid/ready handshake and shifts it out MSB first with the one-bit delay after each wordSelect edge.
module i2s_transmitter #(
    parameter int DATA_SIZE = 32,
    parameter int SLOT_BITS = 32
) (
    input  logic                 sck_clk,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] leftIn,
    input  logic [DATA_SIZE-1:0] rightIn,
    input  logic                 sampleValid,
    output logic                 sampleReady,
    output logic                 wordSelect,
    output logic                 data,
    output logic                 underflow,
    output logic [15:0]          underflowCount
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SLOT_BITS);

    // Left-justify a sample in its slot; bits after the LSB are zero padding.
    function automatic logic [SLOT_BITS-1:0] to_slot(input logic [DATA_SIZE-1:0] s);
        logic [SLOT_BITS-1:0] r;
        r = '0;
        r[SLOT_BITS-1 -: DATA_SIZE] = s;
        return r;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  hold_full, hold_full_nxt;
    logic                  primed, primed_nxt;
    logic [DATA_SIZE-1:0]  hold_left, hold_right;
    logic [FRAME_BITS-1:0] shreg, shreg_nxt;
    logic                  ws_nxt, data_nxt, underflow_nxt;
    logic [15:0]           count_nxt;
    logic                  load, accept;

    assign load        = (cnt == CNT_LAST);
    assign accept      = sampleValid && !hold_full;
    assign sampleReady = !hold_full;

    always_comb begin
        cnt_nxt       = load ? '0 : cnt + CNT_W'(1);
        ws_nxt        = (cnt_nxt >= CNT_HALF);
        // The bit leaving the shift register lags the counter by one, which yields the
        // I2S delay and makes c = 0 carry the last bit of the previous right slot.
        data_nxt      = shreg[FRAME_BITS-1];
        shreg_nxt     = shreg << 1;
        hold_full_nxt = hold_full;
        underflow_nxt = 1'b0;
        count_nxt     = underflowCount;
        primed_nxt    = primed | accept;

        if (load) begin
            shreg_nxt     = hold_full ? {to_slot(hold_left), to_slot(hold_right)} : '0;
            hold_full_nxt = 1'b0;
            underflow_nxt = !hold_full && primed;
        end
        // Accept only happens while empty, so it can never collide with a load draining a full register.
        if (accept) begin
            hold_full_nxt = 1'b1;
        end
        if (underflow_nxt) begin
            count_nxt = sat_inc(underflowCount);
        end
    end

    always_ff @(posedge sck_clk) begin
        if (reset) begin
            cnt            <= CNT_LAST;
            wordSelect     <= 1'b1;
            data           <= 1'b0;
            hold_full      <= 1'b0;
            primed         <= 1'b0;
            underflow      <= 1'b0;
            underflowCount <= 16'd0;
            shreg          <= '0;
        end else begin
            cnt            <= cnt_nxt;
            wordSelect     <= ws_nxt;
            data           <= data_nxt;
            hold_full      <= hold_full_nxt;
            primed         <= primed_nxt;
            underflow      <= underflow_nxt;
            underflowCount <= count_nxt;
            shreg          <= shreg_nxt;
        end
    end

    // Holding data needs no reset: hold_full gates whether it is ever used.
    always_ff @(posedge sck_clk) begin
        if (accept) begin
            hold_left  <= leftIn;
            hold_right <= rightIn;
        end
    end

endmodule
